// File: rtl/vga_arb_pkg.sv
// Shared defaults and the read-owner tag for the VGA frame-buffer arbiter.
package vga_arb_pkg;

    localparam int unsigned DEF_ADDR_W  = 12;
    localparam int unsigned DEF_DATA_W  = 8;
    localparam int unsigned DEF_FAIR_N  = 8;
    localparam int unsigned STALL_CNT_W = 16;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_DISP = 2'd1,
        OWN_CPU  = 2'd2
    } owner_e;

endpackage

// File: rtl/vga_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones once reached.
module vga_sat_counter
    import vga_arb_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_clr,
    input  logic                   i_inc,
    output logic [STALL_CNT_W-1:0] o_cnt
);

    localparam logic [STALL_CNT_W-1:0] CNT_MAX = '1;

    logic [STALL_CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + STALL_CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/vga_vram_arbiter.sv
// Single-port VRAM arbiter: display fetches win, but the CPU is served after FAIR_N
// consecutive display grants while it waits. Read data returns one cycle after grant.
module vga_vram_arbiter
    import vga_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned FAIR_N = DEF_FAIR_N
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_disp_req,
    input  logic [ADDR_W-1:0]      i_disp_addr,
    output logic                   o_disp_gnt,
    output logic [DATA_W-1:0]      o_disp_rdata,
    output logic                   o_disp_rvalid,
    input  logic                   i_cpu_req,
    input  logic                   i_cpu_we,
    input  logic [ADDR_W-1:0]      i_cpu_addr,
    input  logic [DATA_W-1:0]      i_cpu_wdata,
    output logic                   o_cpu_ready,
    output logic [DATA_W-1:0]      o_cpu_rdata,
    output logic                   o_cpu_rvalid,
    output logic                   o_ram_en,
    output logic                   o_ram_we,
    output logic [ADDR_W-1:0]      o_ram_addr,
    output logic [DATA_W-1:0]      o_ram_wdata,
    input  logic [DATA_W-1:0]      i_ram_rdata,
    output logic [STALL_CNT_W-1:0] o_disp_stall_cnt
);

    localparam int unsigned       FC_W     = (FAIR_N < 1) ? 1 : $clog2(FAIR_N + 1);
    localparam logic [FC_W-1:0]   FAIR_MAX = FC_W'(FAIR_N);

    logic [FC_W-1:0]        r_fair_cnt;
    logic [FC_W-1:0]        w_fair_cnt_d;
    owner_e                 r_owner;
    owner_e                 w_owner_d;
    logic                   w_disp_gnt;
    logic                   w_cpu_gnt;
    logic                   w_stall;
    logic [STALL_CNT_W-1:0] w_stall_cnt;

    // Grants are suppressed during reset so no access can leak a read tag past it.
    always_comb begin
        w_disp_gnt = 1'b0;
        w_cpu_gnt  = 1'b0;
        if (!i_reset) begin
            w_disp_gnt = i_disp_req && (!i_cpu_req || (r_fair_cnt < FAIR_MAX));
            w_cpu_gnt  = i_cpu_req && !w_disp_gnt;
        end
    end

    always_comb begin
        w_fair_cnt_d = '0;
        if (w_disp_gnt && i_cpu_req) begin
            w_fair_cnt_d = r_fair_cnt + FC_W'(1);
        end
    end

    always_comb begin
        w_owner_d = OWN_NONE;
        if (w_disp_gnt) begin
            w_owner_d = OWN_DISP;
        end else if (w_cpu_gnt && !i_cpu_we) begin
            w_owner_d = OWN_CPU;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_fair_cnt <= '0;
            r_owner    <= OWN_NONE;
        end else begin
            r_fair_cnt <= w_fair_cnt_d;
            r_owner    <= w_owner_d;
        end
    end

    assign w_stall = i_disp_req && !w_disp_gnt;

    vga_sat_counter u_stall_cnt (
        .i_clk (i_clk),
        .i_clr (i_reset),
        .i_inc (w_stall),
        .o_cnt (w_stall_cnt)
    );

    always_comb begin
        o_disp_gnt       = w_disp_gnt;
        o_cpu_ready      = w_cpu_gnt;
        o_ram_en         = w_disp_gnt || w_cpu_gnt;
        o_ram_we         = w_cpu_gnt && i_cpu_we;
        o_ram_addr       = '0;
        o_ram_wdata      = '0;
        o_disp_rvalid    = 1'b0;
        o_cpu_rvalid     = 1'b0;
        o_disp_rdata     = '0;
        o_cpu_rdata      = '0;
        o_disp_stall_cnt = '0;
        if (w_cpu_gnt) begin
            o_ram_addr = i_cpu_addr;
            if (i_cpu_we) begin
                o_ram_wdata = i_cpu_wdata;
            end
        end else if (w_disp_gnt) begin
            o_ram_addr = i_disp_addr;
        end
        if (!i_reset) begin
            o_disp_stall_cnt = w_stall_cnt;
            if (r_owner == OWN_DISP) begin
                o_disp_rvalid = 1'b1;
                o_disp_rdata  = i_ram_rdata;
            end else if (r_owner == OWN_CPU) begin
                o_cpu_rvalid = 1'b1;
                o_cpu_rdata  = i_ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Directed bench: grant/RAM checks inline, read data checked by a scoreboard monitor;
// a second instance with FAIR_N=0 starves the display to exercise stall saturation.
module tb_vga_vram_arbiter;

    typedef struct packed {
        logic       is_cpu;
        logic [7:0] data;
    } rd_exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        disp_req = 1'b0;
    logic [11:0] disp_addr = '0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [11:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        disp_gnt, disp_rvalid, cpu_ready, cpu_rvalid;
    logic [7:0]  disp_rdata, cpu_rdata;
    logic        ram_en, ram_we;
    logic [11:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata = '0;
    logic [15:0] stall_cnt;

    logic [7:0]  mem [4096];
    rd_exp_t     sb_q[$];
    int          n_total = 0;
    int          n_pass  = 0;
    logic        sat_done = 1'b0;

    // Saturation instance signals
    logic        s_rst = 1'b1;
    logic        s_disp_req = 1'b0;
    logic        s_cpu_req = 1'b0;
    logic [7:0]  s_ram_rdata = '0;
    logic        s_disp_gnt, s_disp_rvalid, s_cpu_ready, s_cpu_rvalid, s_ram_en, s_ram_we;
    logic [7:0]  s_disp_rdata, s_cpu_rdata, s_ram_wdata;
    logic [11:0] s_ram_addr;
    logic [15:0] s_stall_cnt;

    always #5 clk = ~clk;

    vga_vram_arbiter dut (
        .i_clk            (clk),
        .i_reset          (rst),
        .i_disp_req       (disp_req),
        .i_disp_addr      (disp_addr),
        .o_disp_gnt       (disp_gnt),
        .o_disp_rdata     (disp_rdata),
        .o_disp_rvalid    (disp_rvalid),
        .i_cpu_req        (cpu_req),
        .i_cpu_we         (cpu_we),
        .i_cpu_addr       (cpu_addr),
        .i_cpu_wdata      (cpu_wdata),
        .o_cpu_ready      (cpu_ready),
        .o_cpu_rdata      (cpu_rdata),
        .o_cpu_rvalid     (cpu_rvalid),
        .o_ram_en         (ram_en),
        .o_ram_we         (ram_we),
        .o_ram_addr       (ram_addr),
        .o_ram_wdata      (ram_wdata),
        .i_ram_rdata      (ram_rdata),
        .o_disp_stall_cnt (stall_cnt)
    );

    vga_vram_arbiter #(.ADDR_W(12), .DATA_W(8), .FAIR_N(0)) dut_sat (
        .i_clk            (clk),
        .i_reset          (s_rst),
        .i_disp_req       (s_disp_req),
        .i_disp_addr      (12'h010),
        .o_disp_gnt       (s_disp_gnt),
        .o_disp_rdata     (s_disp_rdata),
        .o_disp_rvalid    (s_disp_rvalid),
        .i_cpu_req        (s_cpu_req),
        .i_cpu_we         (1'b0),
        .i_cpu_addr       (12'h020),
        .i_cpu_wdata      (8'h00),
        .o_cpu_ready      (s_cpu_ready),
        .o_cpu_rdata      (s_cpu_rdata),
        .o_cpu_rvalid     (s_cpu_rvalid),
        .o_ram_en         (s_ram_en),
        .o_ram_we         (s_ram_we),
        .o_ram_addr       (s_ram_addr),
        .o_ram_wdata      (s_ram_wdata),
        .i_ram_rdata      (s_ram_rdata),
        .o_disp_stall_cnt (s_stall_cnt)
    );

    // Behavioural single-port VRAM, one-cycle read latency
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic push_rd(input logic is_cpu, input logic [7:0] data);
        rd_exp_t e;
        e.is_cpu = is_cpu;
        e.data   = data;
        sb_q.push_back(e);
    endtask

    task automatic chk_gnt(input string tag, input logic d, input logic c);
        check({tag, "_disp_gnt"}, {31'd0, disp_gnt}, {31'd0, d});
        check({tag, "_cpu_ready"}, {31'd0, cpu_ready}, {31'd0, c});
    endtask

    // Scoreboard monitor: every RVALID must match the oldest outstanding expected read
    always @(negedge clk) begin
        if (disp_rvalid || cpu_rvalid) begin
            if (sb_q.size() == 0) begin
                check("rvalid_unexpected", {30'd0, disp_rvalid, cpu_rvalid}, 32'd0);
            end else begin
                rd_exp_t e;
                e = sb_q.pop_front();
                check("rd_owner", {30'd0, disp_rvalid, cpu_rvalid},
                      e.is_cpu ? 32'd1 : 32'd2);
                if (e.is_cpu) begin
                    check("cpu_rdata", {24'd0, cpu_rdata}, {24'd0, e.data});
                    check("disp_rdata_nonowner", {24'd0, disp_rdata}, 32'd0);
                end else begin
                    check("disp_rdata", {24'd0, disp_rdata}, {24'd0, e.data});
                    check("cpu_rdata_nonowner", {24'd0, cpu_rdata}, 32'd0);
                end
            end
        end
    end

    // Starved display: FAIR_N=0 always hands contested cycles to the CPU
    initial begin
        repeat (2) @(posedge clk);
        #1;
        s_rst      = 1'b0;
        s_disp_req = 1'b1;
        s_cpu_req  = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            @(negedge clk);
            if (i == 5) begin
                check("sat_disp_gnt", {31'd0, s_disp_gnt}, 32'd0);
                check("sat_cpu_ready", {31'd0, s_cpu_ready}, 32'd1);
            end
            if (i == 100)   check("sat_cnt_100", {16'd0, s_stall_cnt}, 32'd100);
            if (i == 65534) check("sat_cnt_fffe", {16'd0, s_stall_cnt}, 32'h0000_FFFE);
            if (i == 65535) check("sat_cnt_ffff", {16'd0, s_stall_cnt}, 32'h0000_FFFF);
        end
        check("sat_cnt_hold", {16'd0, s_stall_cnt}, 32'h0000_FFFF);
        sat_done = 1'b1;
    end

    initial begin
        for (int a = 0; a < 4096; a++) begin
            logic [11:0] av;
            av     = 12'(a);
            mem[a] = av[7:0] ^ 8'h5A;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ram_en", {31'd0, ram_en}, 32'd0);
        check("rst_stall", {16'd0, stall_cnt}, 32'd0);
        chk_gnt("rst", 1'b0, 1'b0);

        // CPU write 0x0A5 <= 3C, first cycle after reset
        @(posedge clk); #1;
        rst = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h0A5; cpu_wdata = 8'h3C;
        @(negedge clk);
        chk_gnt("wr", 1'b0, 1'b1);
        check("wr_ram_we", {31'd0, ram_we}, 32'd1);
        check("wr_ram_addr", {20'd0, ram_addr}, 32'h0A5);
        check("wr_ram_wdata", {24'd0, ram_wdata}, 32'h3C);

        // Display read of the written word
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_we = 1'b0;
        disp_req = 1'b1; disp_addr = 12'h0A5;
        push_rd(1'b0, 8'h3C);
        @(negedge clk);
        chk_gnt("drd", 1'b1, 1'b0);
        check("drd_ram_we", {31'd0, ram_we}, 32'd0);
        check("drd_ram_addr", {20'd0, ram_addr}, 32'h0A5);

        // CPU read alone
        @(posedge clk); #1;
        disp_req = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h0A5;
        push_rd(1'b1, 8'h3C);
        @(negedge clk);
        chk_gnt("crd", 1'b0, 1'b1);

        @(posedge clk); #1;
        cpu_req = 1'b0;
        @(negedge clk);
        check("idle_ram_en", {31'd0, ram_en}, 32'd0);

        // Continuous contention: 8 display grants, then the CPU, repeating
        for (int i = 0; i < 18; i++) begin
            logic [7:0] iv;
            iv = 8'(i);
            @(posedge clk); #1;
            disp_req = 1'b1; disp_addr = 12'(12'h100 + i);
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h0A5;
            if (i % 9 == 8) push_rd(1'b1, 8'h3C);
            else            push_rd(1'b0, iv ^ 8'h5A);
            @(negedge clk);
            chk_gnt("fair", (i % 9) != 8, (i % 9) == 8);
            check("fair_stall", {16'd0, stall_cnt}, 32'(i / 9));
        end

        // CPU drops after 5 contested cycles; fairness restarts on reassertion
        for (int j = 0; j < 15; j++) begin
            logic [7:0] jv;
            jv = 8'(j);
            @(posedge clk); #1;
            disp_req = 1'b1; disp_addr = 12'(12'h200 + j);
            cpu_req = (j != 5);
            if (j == 14) push_rd(1'b1, 8'h3C);
            else         push_rd(1'b0, jv ^ 8'h5A);
            @(negedge clk);
            chk_gnt("restart", j != 14, j == 14);
        end

        @(posedge clk); #1;
        disp_req = 1'b0; cpu_req = 1'b0;
        @(negedge clk);
        check("restart_stall", {16'd0, stall_cnt}, 32'd3);

        // Display read, then reset lands on a would-be CPU read grant
        @(posedge clk); #1;
        disp_req = 1'b1; disp_addr = 12'h300;
        @(negedge clk);
        chk_gnt("prerst", 1'b1, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        disp_req = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h0A5;
        @(negedge clk);
        chk_gnt("inrst", 1'b0, 1'b0);
        check("inrst_ram_en", {31'd0, ram_en}, 32'd0);
        check("inrst_disp_rvalid", {31'd0, disp_rvalid}, 32'd0);
        check("inrst_stall", {16'd0, stall_cnt}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        push_rd(1'b1, 8'h3C);
        @(negedge clk);
        chk_gnt("postrst", 1'b0, 1'b1);
        check("postrst_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
        check("postrst_stall", {16'd0, stall_cnt}, 32'd0);
        @(posedge clk); #1;
        cpu_req = 1'b0;
        repeat (2) @(negedge clk);

        for (int k = 0; k < 80000 && !sat_done; k++) @(posedge clk);
        check("sat_finished", {31'd0, sat_done}, 32'd1);
        check("sb_drained", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vga_vram_arbiter.md
VGA_VRAM_ARBITER -- requirements
Module: vga_vram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12, VRAM word address width (4096-entry frame buffer).
REQ-002 Parameter DATA_W, default 8, pixel width (RGB 3:3:2).
REQ-003 Parameter FAIR_N, default 8, consecutive display grants tolerated while CPU waits.
REQ-004 CLK  in  1  single clock; all state on rising edge.
REQ-005 RESET  in  1  synchronous, active-high reset.
REQ-006 DISP_REQ  in  1  display fetch request, held until granted.
REQ-007 DISP_ADDR  in  ADDR_W  display read address.
REQ-008 DISP_GNT  out  1  display access performed this cycle.
REQ-009 DISP_RDATA  out  DATA_W  display read data.
REQ-010 DISP_RVALID  out  1  DISP_RDATA valid.
REQ-011 CPU_REQ  in  1  CPU access request, held until accepted.
REQ-012 CPU_WE  in  1  1 = write, 0 = read.
REQ-013 CPU_ADDR  in  ADDR_W  CPU address.
REQ-014 CPU_WDATA  in  DATA_W  CPU write data.
REQ-015 CPU_READY  out  1  CPU access performed this cycle.
REQ-016 CPU_RDATA  out  DATA_W  CPU read data.
REQ-017 CPU_RVALID  out  1  CPU_RDATA valid.
REQ-018 RAM_EN, RAM_WE  out  1 each  single-port VRAM enable and write enable.
REQ-019 RAM_ADDR  out  ADDR_W; RAM_WDATA  out  DATA_W; RAM_RDATA  in  DATA_W (one-cycle read latency).
REQ-020 DISP_STALL_CNT  out  16  saturating count of cycles with DISP_REQ high and DISP_GNT low.

Function
REQ-021 The block SHALL make at most one RAM access per cycle; DISP_GNT and CPU_READY are never both 1.
REQ-022 Grant decision SHALL be combinational from the requests and the registered fairness counter; RAM_EN/RAM_WE/RAM_ADDR/RAM_WDATA SHALL be driven from the granted port in that same cycle.
REQ-023 Only DISP_REQ: display granted. Only CPU_REQ: CPU granted. Neither: RAM_EN=0, RAM_WE=0.
REQ-024 Both requesting and fair_cnt < FAIR_N: display granted; fair_cnt increments.
REQ-025 Both requesting and fair_cnt = FAIR_N: CPU granted, display denied (stall counted).
REQ-026 fair_cnt SHALL clear whenever the CPU is granted or CPU_REQ is low; it never exceeds FAIR_N.
REQ-027 RAM_WE = CPU_WE only on a CPU grant; display accesses are always reads.
REQ-028 A registered owner tag (NONE/DISP/CPU_RD) SHALL record each read grant; the following cycle the owner's RVALID is 1 and its RDATA carries RAM_RDATA. CPU writes produce no RVALID.
REQ-029 Non-owner RDATA outputs SHALL be 0; both RVALIDs are 0 when the tag is NONE.
REQ-030 Back-to-back grants SHALL sustain one access per cycle with no bubble; read latency is exactly 1 cycle from grant.
REQ-031 DISP_STALL_CNT SHALL hold at 16'hFFFF once reached.

Reset
REQ-032 While RESET is high, all outputs SHALL be 0, fair_cnt = 0, owner tag = NONE, DISP_STALL_CNT = 0.
REQ-033 A read granted in the cycle RESET is asserted SHALL NOT produce RVALID in the following cycle.
REQ-034 The first grant may occur in the first cycle after RESET falls.

Structure
REQ-035 Package vga_arb_pkg SHALL hold default ADDR_W, DATA_W, FAIR_N and the owner-tag enum (OWN_NONE, OWN_DISP, OWN_CPU).
REQ-036 Sub-module vga_sat_counter (16-bit saturating counter with inc and synchronous clear) SHALL implement DISP_STALL_CNT; everything else is flat.

Verification
REQ-037 CPU write 0x0A5 <= 8'h3C, no display traffic -> CPU_READY=1, RAM_WE=1, RAM_ADDR=0x0A5 in the same cycle; no RVALID follows.
REQ-038 Display read 0x0A5 after the write -> DISP_GNT=1; next cycle DISP_RVALID=1, DISP_RDATA=8'h3C, CPU_RVALID=0.
REQ-039 DISP_REQ and CPU_REQ (read) held continuously -> 8 display grants, 9th cycle CPU_READY=1, DISP_STALL_CNT=1; pattern repeats every 9 cycles.
REQ-040 DISP_REQ held high, display never granted for 70000 cycles (forced via fairness) -> DISP_STALL_CNT saturates at 16'hFFFF.
REQ-041 Assert RESET in the cycle of a CPU read grant -> CPU_RVALID=0 next cycle; all outputs 0 and DISP_STALL_CNT=0.
REQ-042 CPU_REQ drops after 5 contested cycles, then reasserts -> fair_cnt restarts; CPU granted only after 8 further display grants.
